// File: rtl/mmio_fifo_pkg.sv
// Shared types and register map for the MMIO controller of the AFU shift-register FIFO.
package mmio_fifo_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } t_ctrl_state;

  localparam logic [2:0] OFF_DATA    = 3'd0;
  localparam logic [2:0] OFF_STATUS  = 3'd2;
  localparam logic [2:0] OFF_CTRL    = 3'd4;
  localparam logic [2:0] OFF_PUSHCNT = 3'd6;

  // STATUS register image, listed MSB first so q_valid lands on bit 0.
  typedef struct packed {
    logic [31:0] rsvd_hi;
    logic [15:0] pushcnt_lo;
    logic [5:0]  rsvd_lo;
    logic [4:0]  count;
    logic        busy;
    logic        drop_sticky;
    logic        unf_sticky;
    logic        ovf_sticky;
    logic        q_valid;
  } t_fifo_status;

endpackage

// File: rtl/mmio_csr_decode.sv
// Combinational decode of the 8-DWORD CSR window into one-hot register selects.
module mmio_csr_decode
  import mmio_fifo_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0020
) (
  input  logic [15:0] addr,
  output logic        hit,
  output logic        sel_data,
  output logic        sel_status,
  output logic        sel_ctrl,
  output logic        sel_pushcnt
);

  logic [15:0] offset;

  // Wrapping subtraction turns below-base addresses into huge offsets, so one compare covers both ends.
  always_comb begin
    offset      = addr - BASE_ADDR;
    hit         = (offset[15:3] == 13'd0);
    sel_data    = hit && (offset[2:0] == OFF_DATA);
    sel_status  = hit && (offset[2:0] == OFF_STATUS);
    sel_ctrl    = hit && (offset[2:0] == OFF_CTRL);
    sel_pushcnt = hit && (offset[2:0] == OFF_PUSHCNT);
  end

endmodule

// File: rtl/mmio_fifo_ctrl.sv
// MMIO controller for the AFU delay-line FIFO: pushes, occupancy tracking, flush sequencing
// and single-cycle CSR read responses.
module mmio_fifo_ctrl
  import mmio_fifo_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [15:0] BASE_ADDR = 16'h0020,
  parameter int          CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmio_wr_valid,
  input  logic        mmio_rd_valid,
  input  logic [15:0] mmio_addr,
  input  logic [8:0]  mmio_tid,
  input  logic [63:0] mmio_wr_data,
  output logic        fifo_en,
  output logic [63:0] fifo_d,
  input  logic [63:0] fifo_q,
  output logic        rd_rsp_valid,
  output logic        rd_hit,
  output logic [8:0]  rd_rsp_tid,
  output logic [63:0] rd_rsp_data
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  t_ctrl_state      state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] flush_ctr;
  logic [31:0]      pushcnt;
  logic             ovf_sticky, unf_sticky, drop_sticky;

  logic hit, sel_data, sel_status, sel_ctrl, sel_pushcnt;
  logic q_valid, push, drop, flush_start, clr, ovf_set, unf_set;
  t_fifo_status status;
  logic [63:0]  rd_mux;

  mmio_csr_decode #(.BASE_ADDR(BASE_ADDR)) u_decode (
    .addr        (mmio_addr),
    .hit         (hit),
    .sel_data    (sel_data),
    .sel_status  (sel_status),
    .sel_ctrl    (sel_ctrl),
    .sel_pushcnt (sel_pushcnt)
  );

  always_comb begin
    q_valid     = (count == DEPTH_C);
    push        = mmio_wr_valid && sel_data && (state == IDLE);
    drop        = mmio_wr_valid && sel_data && (state == FLUSH);
    flush_start = mmio_wr_valid && sel_ctrl && mmio_wr_data[0] && (state == IDLE);
    clr         = mmio_wr_valid && sel_ctrl && mmio_wr_data[1];
    ovf_set     = push && q_valid;
    unf_set     = mmio_rd_valid && sel_data && !q_valid;
  end

  // Read mux works on pre-write state; the response register below adds the one cycle of latency.
  always_comb begin
    status             = '0;
    status.pushcnt_lo  = pushcnt[15:0];
    status.count       = 5'(count);
    status.busy        = (state == FLUSH);
    status.drop_sticky = drop_sticky;
    status.unf_sticky  = unf_sticky;
    status.ovf_sticky  = ovf_sticky;
    status.q_valid     = q_valid;
    rd_mux             = 64'd0;
    if (sel_data) begin
      rd_mux = q_valid ? fifo_q : 64'd0;
    end else if (sel_status) begin
      rd_mux = status;
    end else if (sel_pushcnt) begin
      rd_mux = {32'd0, pushcnt};
    end else begin
      rd_mux = 64'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      flush_ctr <= '0;
      pushcnt   <= 32'd0;
      fifo_en   <= 1'b0;
      fifo_d    <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_start) begin
            state     <= FLUSH;
            flush_ctr <= DEPTH_C;
            fifo_en   <= 1'b1;
            fifo_d    <= 64'd0;
          end else if (push) begin
            fifo_en <= 1'b1;
            fifo_d  <= mmio_wr_data;
            count   <= q_valid ? count : count + ONE_C;
            pushcnt <= pushcnt + 32'd1;
          end else begin
            fifo_en <= 1'b0;
          end
        end
        FLUSH: begin
          fifo_d <= 64'd0;
          // The shift issued on entry counts as the first, so leaving at 1 gives DEPTH shifts.
          if (flush_ctr == ONE_C) begin
            state     <= IDLE;
            flush_ctr <= '0;
            count     <= '0;
            fifo_en   <= 1'b0;
          end else begin
            flush_ctr <= flush_ctr - ONE_C;
            fifo_en   <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          fifo_en <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky  <= 1'b0;
      unf_sticky  <= 1'b0;
      drop_sticky <= 1'b0;
    end else begin
      ovf_sticky  <= ovf_set || (ovf_sticky  && !clr);
      unf_sticky  <= unf_set || (unf_sticky  && !clr);
      drop_sticky <= drop    || (drop_sticky && !clr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_rsp_valid <= 1'b0;
      rd_hit       <= 1'b0;
      rd_rsp_tid   <= 9'd0;
      rd_rsp_data  <= 64'd0;
    end else begin
      rd_rsp_valid <= mmio_rd_valid;
      rd_hit       <= mmio_rd_valid && hit;
      rd_rsp_tid   <= mmio_rd_valid ? mmio_tid : 9'd0;
      rd_rsp_data  <= mmio_rd_valid ? rd_mux : 64'd0;
    end
  end

endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// Scoreboard bench for mmio_fifo_ctrl with a behavioural delay-line FIFO attached.
module tb_mmio_fifo_ctrl;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mmio_wr_valid = 1'b0;
  logic        mmio_rd_valid = 1'b0;
  logic [15:0] mmio_addr = 16'd0;
  logic [8:0]  mmio_tid = 9'd0;
  logic [63:0] mmio_wr_data = 64'd0;
  logic        fifo_en;
  logic [63:0] fifo_d;
  logic [63:0] fifo_q;
  logic        rd_rsp_valid, rd_hit;
  logic [8:0]  rd_rsp_tid;
  logic [63:0] rd_rsp_data;

  int errors = 0;
  int checks = 0;
  logic ignore_en = 1'b0;

  typedef struct packed {
    logic        hit;
    logic [8:0]  tid;
    logic [63:0] data;
  } t_rsp;

  t_rsp        rsp_q[$];
  logic [63:0] en_q[$];
  logic [63:0] stage [DEPTH];

  localparam logic [15:0] A_DATA = 16'h0020, A_STATUS = 16'h0022,
                          A_CTRL = 16'h0024, A_PCNT = 16'h0026;

  mmio_fifo_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(16'h0020)) dut (
    .clk(clk), .rst(rst),
    .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wr_data(mmio_wr_data),
    .fifo_en(fifo_en), .fifo_d(fifo_d), .fifo_q(fifo_q),
    .rd_rsp_valid(rd_rsp_valid), .rd_hit(rd_hit),
    .rd_rsp_tid(rd_rsp_tid), .rd_rsp_data(rd_rsp_data)
  );

  always #5 clk = ~clk;

  // Plant: DEPTH-stage delay line, not cleared by reset.
  initial for (int i = 0; i < DEPTH; i++) stage[i] = 64'd0;
  always @(posedge clk) begin
    if (fifo_en) begin
      stage[0] <= fifo_d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end
  assign fifo_q = stage[DEPTH-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a response or a shift.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          t_rsp e;
          e = rsp_q.pop_front();
          check("rd_hit", 64'(rd_hit), 64'(e.hit));
          check("rd_tid", 64'(rd_rsp_tid), 64'(e.tid));
          check("rd_data", rd_rsp_data, e.data);
        end
      end
      if (fifo_en && !ignore_en) begin
        if (en_q.size() == 0) check("unexpected_fifo_en", 64'd1, 64'd0);
        else check("fifo_d", fifo_d, en_q.pop_front());
      end
    end
  end

  task automatic wr(input logic [15:0] a, input logic [63:0] d, input bit exp_push,
                    input int n_zero_shifts);
    if (exp_push) en_q.push_back(d);
    for (int i = 0; i < n_zero_shifts; i++) en_q.push_back(64'd0);
    mmio_wr_valid = 1'b1; mmio_addr = a; mmio_wr_data = d;
    @(negedge clk);
    mmio_wr_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [15:0] a, input logic [8:0] t, input logic h, input logic [63:0] d);
    rsp_q.push_back('{hit: h, tid: t, data: d});
    mmio_rd_valid = 1'b1; mmio_addr = a; mmio_tid = t;
    @(negedge clk);
    mmio_rd_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_fifo_en", 64'(fifo_en), 64'd0);
    check("rst_rsp_valid", 64'(rd_rsp_valid), 64'd0);
    check("rst_rd_hit", 64'(rd_hit), 64'd0);
    check("rst_rsp_data", rd_rsp_data, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    rd(A_STATUS, 9'd5, 1'b1, 64'd0);
    rd(16'h0000, 9'd6, 1'b0, 64'd0);
    rd(16'h0021, 9'd7, 1'b1, 64'd0);
    rd(A_CTRL,   9'd8, 1'b1, 64'd0);

    for (int v = 1; v <= 3; v++) wr(A_DATA, 64'(v), 1'b1, 0);
    rd(A_DATA,   9'd9,  1'b1, 64'd0);
    rd(A_STATUS, 9'd10, 1'b1, 64'h0003_0064);
    wr(A_CTRL, 64'd2, 1'b0, 0);
    rd(A_STATUS, 9'd11, 1'b1, 64'h0003_0060);

    for (int v = 4; v <= 8; v++) wr(A_DATA, 64'(v), 1'b1, 0);
    rd(A_STATUS, 9'd12, 1'b1, 64'h0008_0101);
    rd(A_DATA,   9'd13, 1'b1, 64'd1);

    wr(A_DATA, 64'd9, 1'b1, 0);
    rd(A_STATUS, 9'd14, 1'b1, 64'h0009_0103);
    rd(A_DATA,   9'd15, 1'b1, 64'd2);
    rd(A_PCNT,   9'd16, 1'b1, 64'd9);

    wr(A_CTRL, 64'd1, 1'b0, DEPTH);
    rd(A_STATUS, 9'd17, 1'b1, 64'h0009_0113);
    wr(A_DATA, 64'h77, 1'b0, 0);
    repeat (12) @(negedge clk);
    rd(A_STATUS, 9'd18, 1'b1, 64'h0009_000A);

    // Read and write to DATA together: read sees empty FIFO, write still pushes.
    en_q.push_back(64'h55);
    rsp_q.push_back('{hit: 1'b1, tid: 9'd19, data: 64'd0});
    mmio_wr_valid = 1'b1; mmio_rd_valid = 1'b1;
    mmio_addr = A_DATA; mmio_wr_data = 64'h55; mmio_tid = 9'd19;
    @(negedge clk);
    mmio_wr_valid = 1'b0; mmio_rd_valid = 1'b0;
    @(negedge clk);
    rd(A_STATUS, 9'd20, 1'b1, 64'h000A_002E);
    wr(A_CTRL, 64'd2, 1'b0, 0);
    rd(A_STATUS, 9'd21, 1'b1, 64'h000A_0020);

    force dut.pushcnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.pushcnt;
    wr(A_DATA, 64'hA1, 1'b1, 0);
    wr(A_DATA, 64'hA2, 1'b1, 0);
    rd(A_PCNT,   9'd22, 1'b1, 64'd1);
    rd(A_STATUS, 9'd23, 1'b1, 64'h0001_0060);

    ignore_en = 1'b1;
    wr(A_CTRL, 64'd1, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_midflush_en", 64'(fifo_en), 64'd0);
    @(negedge clk);
    check("rst_midflush_en_next", 64'(fifo_en), 64'd0);
    rst = 1'b0;
    ignore_en = 1'b0;
    @(negedge clk);
    rd(A_STATUS, 9'd24, 1'b1, 64'd0);
    rd(A_PCNT,   9'd25, 1'b1, 64'd0);

    for (int i = 0; i < 50 && (rsp_q.size() != 0 || en_q.size() != 0); i++) @(negedge clk);
    check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    check("en_q_drained", 64'(en_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
